// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level RV32I requests into 32-bit words, buffers them in a
// FIFO and streams them out with word addresses. Optional feature macro: ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              fmt,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct75,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [31:0]             imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]           mem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [31:0]           word;
  logic                  fmtOk, immBad, accept, push, pop;

  always_comb begin
    word = '0;
    fmtOk = 1'b1;
    word[6:0] = opcode;
    case (fmt)
      3'b000: begin
        word[11:7]  = rd;
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[31:20] = imm[11:0];
        // srli/srai share funct3; bit 30 selects arithmetic shift
        if (opcode == 7'b0010011 && funct3 == 3'b101) word[30] = funct75;
      end
      3'b001: begin
        word[11:7]  = imm[4:0];
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[31:25] = imm[11:5];
      end
      3'b010: begin
        word[7]     = imm[11];
        word[11:8]  = imm[4:1];
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[30:25] = imm[10:5];
        word[31]    = imm[12];
      end
      3'b011: begin
        word[11:7]  = rd;
        word[19:12] = imm[19:12];
        word[20]    = imm[11];
        word[30:21] = imm[10:1];
        word[31]    = imm[20];
      end
      3'b100: begin
        word[11:7]  = rd;
        word[31:12] = imm[31:12];
      end
      3'b101: begin
        word[11:7]  = rd;
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[30]    = funct75;
      end
      default: begin
        word  = '0;
        fmtOk = 1'b0;
      end
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    immBad = 1'b0;
    case (fmt)
      3'b000, 3'b001: immBad = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
      3'b010:         immBad = ($signed(imm) < -32'sd4096) || ($signed(imm) > 32'sd4094) || imm[0];
      3'b011:         immBad = ($signed(imm) < -32'sd1048576) || ($signed(imm) > 32'sd1048574) || imm[0];
      3'b100:         immBad = |imm[11:0];
      default:        immBad = 1'b0;
    endcase
  end
`else
  assign immBad = 1'b0;
`endif

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && fmtOk;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    addr_d  = pop ? addr_q + ADDR_WIDTH'(4) : addr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    err_d = err_q || (accept && (!fmtOk || immBad));
  end

  // start shares the reset path so it overrides both handshakes in its cycle
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !start && push) mem_q[wrPtr_q] <= word;
  end

  assign out_instr = out_valid ? mem_q[rdPtr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed test-plan cases plus randomized traffic checked against a
// queue-based reference model of the encoder/FIFO (honours ENCODER_RANGE_CHECK_EN).
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam logic [AW-1:0] BASE = '0;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, funct75, out_valid, out_ready, err;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, out_instr;
  logic [AW-1:0] out_addr;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];
  logic [AW-1:0] expAddr;
  bit expErr;
  bit lastAccepted;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct75(funct75), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic longint unsigned fieldOf(longint unsigned v, int lo, int width);
    return (v >> lo) % (64'd1 << width);
  endfunction

  // Place-value construction of the instruction word straight from the format tables
  function automatic logic [31:0] refEncode(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic f75, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [31:0] im);
    longint unsigned u, w, immField, regs;
    u = im;
    regs = longint'(f3) * 4096 + longint'(s1) * 32768;
    case (f)
      3'd0: begin
        immField = fieldOf(u, 0, 12);
        if (op == 7'h13 && f3 == 3'd5)
          immField = immField - fieldOf(immField, 10, 1) * 1024 + longint'(f75) * 1024;
        w = op + longint'(d) * 128 + regs + immField * 1048576;
      end
      3'd1: w = op + regs + longint'(s2) * 1048576 + fieldOf(u, 0, 5) * 128 + fieldOf(u, 5, 7) * 33554432;
      3'd2: w = op + regs + longint'(s2) * 1048576 + fieldOf(u, 11, 1) * 128 + fieldOf(u, 1, 4) * 256
                + fieldOf(u, 5, 6) * 33554432 + fieldOf(u, 12, 1) * 64'd2147483648;
      3'd3: w = op + longint'(d) * 128 + fieldOf(u, 12, 8) * 4096 + fieldOf(u, 11, 1) * 1048576
                + fieldOf(u, 1, 10) * 2097152 + fieldOf(u, 20, 1) * 64'd2147483648;
      3'd4: w = op + longint'(d) * 128 + fieldOf(u, 12, 20) * 4096;
      default: w = op + longint'(d) * 128 + regs + longint'(s2) * 1048576 + longint'(f75) * 1073741824;
    endcase
    return 32'(w);
  endfunction

  function automatic bit rangeBad(input logic [2:0] f, input logic [31:0] im);
    int s;
    s = im;
    case (f)
      3'd0, 3'd1: return (s < -2048) || (s > 2047);
      3'd2: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd3: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      3'd4: return (im % 4096) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Compare against the model, then advance model and DUT by one clock
  task automatic applyStimulus();
    bit doPop, doPush;
    checkOutput("count", 32'(count), 32'(expQ.size()));
    checkOutput("in_ready", 32'(in_ready), (expQ.size() < DEPTH) ? 32'd1 : 32'd0);
    checkOutput("out_valid", 32'(out_valid), (expQ.size() > 0) ? 32'd1 : 32'd0);
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("out_addr", out_addr, expAddr);
    checkOutput("out_instr", out_instr, (expQ.size() > 0) ? expQ[0] : 32'h0);
    lastAccepted = 1'b0;
    if (!rst_n || start) begin
      expQ.delete();
      expAddr = BASE;
      expErr = 1'b0;
    end else begin
      doPop = (expQ.size() > 0) && out_ready;
      doPush = in_valid && (expQ.size() < DEPTH);
      if (doPush) begin
        lastAccepted = 1'b1;
        if (fmt > 3'd5) expErr = 1'b1;
        else begin
          expQ.push_back(refEncode(fmt, opcode, funct3, funct75, rd, rs1, rs2, imm));
`ifdef ENCODER_RANGE_CHECK_EN
          if (rangeBad(fmt, imm)) expErr = 1'b1;
`endif
        end
      end
      if (doPop) begin
        void'(expQ.pop_front());
        expAddr = expAddr + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic f75, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] im);
    in_valid = 1'b1; fmt = f; opcode = op; funct3 = f3; funct75 = f75;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic pushUntilAccepted();
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (lastAccepted) break;
    end
    if (!lastAccepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    setReq(3'd0, 7'h0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.delete(); expAddr = BASE; expErr = 1'b0;
    checkOutput("rstReady", 32'(in_ready), 32'd1);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstInstr", out_instr, 32'h0);
    checkOutput("rstAddr", out_addr, 32'h0);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);

    // addi x1,x0,5 with consumer ready
    out_ready = 1'b1;
    setReq(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    pushUntilAccepted();
    checkOutput("addiWord", out_instr, 32'h00500093);
    checkOutput("addiAddr", out_addr, 32'h0);
    applyStimulus();

    // add / sub
    doStart();
    out_ready = 1'b0;
    setReq(3'd5, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    pushUntilAccepted();
    setReq(3'd5, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    pushUntilAccepted();
    checkOutput("addWord", out_instr, 32'h002081B3);
    checkOutput("addAddr", out_addr, 32'h0);
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("subWord", out_instr, 32'h402081B3);
    checkOutput("subAddr", out_addr, 32'h4);
    applyStimulus();

    // sw / beq / jal
    doStart();
    out_ready = 1'b0;
    setReq(3'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    pushUntilAccepted();
    setReq(3'd2, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
    pushUntilAccepted();
    setReq(3'd3, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    pushUntilAccepted();
    out_ready = 1'b1;
    checkOutput("swWord", out_instr, 32'h0020A423);
    checkOutput("swAddr", out_addr, 32'h0);
    applyStimulus();
    checkOutput("beqWord", out_instr, 32'hFE208EE3);
    checkOutput("beqAddr", out_addr, 32'h4);
    applyStimulus();
    checkOutput("jalWord", out_instr, 32'h008000EF);
    checkOutput("jalAddr", out_addr, 32'h8);
    applyStimulus();

    // fill the FIFO, hold the fifth request, then drain
    doStart();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      setReq(3'd0, 7'h13, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k));
      pushUntilAccepted();
    end
    checkOutput("fullCount", 32'(count), 32'd4);
    checkOutput("fullReady", 32'(in_ready), 32'd0);
    setReq(3'd0, 7'h13, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd4);
    applyStimulus();
    applyStimulus();
    checkOutput("heldFifth", 32'(lastAccepted), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("drainValid", 32'(out_valid), 32'd1);
      checkOutput("drainAddr", out_addr, 32'(k * 4));
      applyStimulus();
      if (lastAccepted) in_valid = 1'b0;
    end
    checkOutput("drainEmpty", 32'(count), 32'd0);

    // start pulsed mid-stream with a request pending
    doStart();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setReq(3'd4, 7'h37, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k) << 12);
      pushUntilAccepted();
    end
    setReq(3'd0, 7'h13, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd9);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("startNoAccept", 32'(lastAccepted), 32'd0);
    checkOutput("startCount", 32'(count), 32'd0);
    checkOutput("startValid", 32'(out_valid), 32'd0);
    checkOutput("startErr", 32'(err), 32'd0);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("postStartAddr", out_addr, BASE);
    checkOutput("postStartValid", 32'(out_valid), 32'd1);

    // illegal format and out-of-range immediate
    doStart();
    setReq(3'd7, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("illegalErr", 32'(err), 32'd1);
    checkOutput("illegalCount", 32'(count), 32'd0);
    doStart();
    setReq(3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("bigImmWord", out_instr, 32'h00000093);
`ifdef ENCODER_RANGE_CHECK_EN
    checkOutput("bigImmErr", 32'(err), 32'd1);
`else
    checkOutput("bigImmErr", 32'(err), 32'd0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] fr;
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      fr = 4'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      fmt = (fr < 4'd8) ? fr[2:0] : 3'(fr % 6);
      opcode = 7'($urandom); funct3 = 3'($urandom); funct75 = 1'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case ($urandom_range(0, 2))
        0: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        1: imm = 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'd1;
        default: imm = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) imm = {imm[31:12], 12'h0};
      applyStimulus();
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program streamer. It is the inverse of the control decoder: it accepts field-level instruction requests (format, opcode, funct3, funct7[5], registers, immediate) and packs them into 32-bit RISC-V words. The words are buffered in a small FIFO and streamed out with sequentially incrementing word addresses. It sits in front of instruction memory as a program loader and drives self-checking decode benches.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_WIDTH, 32, width of out_addr
- BASE_ADDR, 0, first output address after reset/start

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  flush FIFO, reload address to BASE_ADDR, clear err
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept (FIFO not full)
- fmt  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 110/111 illegal
- opcode  input  7  op field
- funct3  input  3  funct3 field
- funct75  input  1  funct7[5] (R-type, I-type shift-right)
- rd, rs1, rs2  input  5 each  register indices
- imm  input  32  signed immediate (U: full value, low 12 bits ignored)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_instr  output  32  encoded word at head
- out_addr  output  ADDR_WIDTH  address for out_instr
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- err  output  1  sticky error flag

## Operation
- Accept on in_valid & in_ready; encoding combinational, result pushed into FIFO at that edge.
- Field packing: op→[6:0], rd→[11:7], funct3→[14:12], rs1→[19:15], rs2→[24:20].
  - R: [31:25] = {0, funct75, 00000}.
  - I: imm[11:0]→[31:20]; if opcode=0010011 and funct3=101, bit 30 = funct75.
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
  - Fields not used by a format are zero.
- Illegal fmt: request accepted (in_ready honoured), nothing pushed, err set.
- Output: head popped on out_valid & out_ready; out_addr += 4 per pop, wraps modulo 2^ADDR_WIDTH.
- FIFO full: in_ready=0, no bypass. Push and pop in the same cycle when not full: count unchanged.
- start (while rst_n=1): takes priority over both handshakes that cycle. Next cycle: count=0, out_valid=0, out_addr=BASE_ADDR, err=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, err=0.
- Latency: request accepted at edge N → out_valid=1 with word from N+1; no combinational in→out path.
- in_ready depends only on registered count.
- Reset or start mid-stream discards buffered words and any handshake that cycle.
- err sets the edge after the offending accept and remains set until rst_n=0 or start.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: accepted requests with an unrepresentable immediate set err; the word is still pushed, truncated. Unrepresentable means:
  - I/S outside −2048..2047.
  - B outside −4096..4094, or odd.
  - J outside ±1 MiB, or odd.
  - U with imm[11:0]≠0.
- Undefined: immediates silently truncated per packing rules; err set only by illegal fmt.

## Test plan
- addi x1,x0,5 (fmt I, op 0010011, f3 000, rd 1, imm 5), out_ready=1 → out_instr 0x00500093, out_addr 0x0 one cycle after accept.
- add then sub x3,x1,x2 (fmt R, op 0110011, funct75 0/1) → 0x002081B3 @0x0, 0x402081B3 @0x4.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,-4 → 0xFE208EE3; jal x1,8 → 0x008000EF; consecutive addresses 0x0, 0x4, 0x8.
- DEPTH=4, out_ready=0, five valid requests → in_ready low after 4th accept, count=4, 5th held. Raise out_ready → addresses 0x0, 0x4, 0x8, 0xC, then 0x10 for the 5th.
- Three words buffered, start pulsed with in_valid=1 → next cycle count=0, out_valid=0, err=0, request not accepted. Next word emerges at BASE_ADDR.
- fmt 111 → nothing pushed, err=1. I-type imm 4096: with ENCODER_RANGE_CHECK_EN err=1 and word 0x00000093-style (imm bits 0); without, err=0, same word.
